// File: rtl/fwd_hazard_tracker_if.sv
// ID-stage request / EXE-select response bundle for fwd_hazard_tracker.
// FWD_STATS_EN adds the stall/forward counter outputs.
interface fwd_hazard_tracker_if #(
    parameter int NUM_SRC = 3,
    parameter int AW      = 5,
    parameter int DEPTH   = 3
);
    localparam int SELW = $clog2(DEPTH + 2);

    logic                    id_valid;
    logic [NUM_SRC*AW-1:0]   id_src;
    logic [NUM_SRC-1:0]      id_src_used;
    logic [AW-1:0]           id_dest;
    logic                    id_wb_en;
    logic                    id_is_load;
    logic                    pipe_freeze;
    logic                    flush;
    logic [NUM_SRC*SELW-1:0] fwd_sel;
    logic                    stall;
`ifdef FWD_STATS_EN
    logic [15:0]             stall_cnt;
    logic [15:0]             fwd_cnt;
`endif

    modport master (
        output id_valid, id_src, id_src_used, id_dest, id_wb_en, id_is_load,
               pipe_freeze, flush,
`ifdef FWD_STATS_EN
        input  stall_cnt, fwd_cnt,
`endif
        input  fwd_sel, stall
    );

    modport slave (
        input  id_valid, id_src, id_src_used, id_dest, id_wb_en, id_is_load,
               pipe_freeze, flush,
`ifdef FWD_STATS_EN
        output stall_cnt, fwd_cnt,
`endif
        output fwd_sel, stall
    );
endinterface

// File: rtl/fwd_hazard_tracker.sv
// Forwarding-select and load-use stall unit with a DEPTH-stage producer shadow.
// Optional FWD_STATS_EN adds saturating stall and forward counters.
module fwd_hazard_tracker #(
    parameter int NUM_SRC = 3,
    parameter int AW      = 5,
    parameter int DEPTH   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fwd_hazard_tracker_if.slave  bus
);
    localparam int SELW = $clog2(DEPTH + 2);

    typedef struct packed {
        logic          vld;
        logic          wb;
        logic          ld;
        logic [AW-1:0] dest;
    } stage_t;

    stage_t                            r_stg [1:DEPTH];
    logic [NUM_SRC-1:0][SELW-1:0]      r_sel;
    logic [NUM_SRC-1:0][SELW-1:0]      w_sel;
    logic [NUM_SRC-1:0][AW-1:0]        w_src;
    logic                              w_ld_hit;
    logic                              w_stall;
    stage_t                            w_id;

    assign w_src = bus.id_src;
    assign w_id  = '{vld: bus.id_valid, wb: bus.id_wb_en, ld: bus.id_is_load, dest: bus.id_dest};

    // Descending scan so the youngest producer overwrites older matches; stage DEPTH
    // is skipped because the register file writes through during WB.
    always_comb begin
        w_sel    = '0;
        w_ld_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (bus.id_src_used[i]) begin
                if (w_src[i] == '0) begin
                    w_sel[i] = '1;
                end else begin
                    for (int k = DEPTH - 1; k >= 1; k--) begin
                        if (r_stg[k].vld && r_stg[k].wb && r_stg[k].dest == w_src[i])
                            w_sel[i] = SELW'(k + 1);
                    end
                    if (r_stg[1].vld && r_stg[1].wb && r_stg[1].ld && r_stg[1].dest == w_src[i])
                        w_ld_hit = 1'b1;
                end
            end
        end
    end

    assign w_stall     = bus.id_valid & ~bus.flush & w_ld_hit;
    assign bus.stall   = w_stall;
    assign bus.fwd_sel = r_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= DEPTH; k++) r_stg[k] <= '0;
            r_sel <= '0;
        end else if (!bus.pipe_freeze) begin
            for (int k = 2; k <= DEPTH; k++) r_stg[k] <= r_stg[k-1];
            if (bus.flush || w_stall) begin
                r_stg[1] <= '0;
                r_sel    <= '0;
            end else begin
                r_stg[1] <= w_id;
                r_sel    <= w_sel;
            end
        end
    end

`ifdef FWD_STATS_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_fwd_cnt;
    logic        w_any_fwd;

    always_comb begin
        w_any_fwd = 1'b0;
        for (int i = 0; i < NUM_SRC; i++)
            if (w_sel[i] != '0 && w_sel[i] != '1) w_any_fwd = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_fwd_cnt   <= '0;
        end else if (!bus.pipe_freeze) begin
            if (w_stall && r_stall_cnt != 16'hFFFF)
                r_stall_cnt <= r_stall_cnt + 16'd1;
            if (!bus.flush && !w_stall && w_any_fwd && r_fwd_cnt != 16'hFFFF)
                r_fwd_cnt <= r_fwd_cnt + 16'd1;
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
    assign bus.fwd_cnt   = r_fwd_cnt;
`endif
endmodule
